// File: rtl/my_cpu16_ctrl.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// Fetches a 16-bit instruction as two byte reads (high byte first), decodes it,
// then issues a single EXEC cycle carrying the register write and ALU selects.
module my_cpu16_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        RUN,
  input  logic        STEP,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic [3:0]  REG_N1,
  output logic [3:0]  REG_N2,
  output logic [3:0]  REG_WN,
  output logic        REG_WE,
  output logic        S_SUB,
  output logic        S_FAS,
  output logic        S_AND,
  output logic        S_OR,
  output logic        S_XOR,
  output logic        S_NOT,
  output logic        SEL_IMM,
  output logic [15:0] IMM,
  output logic        SEL_LDIN,
  output logic        HALTED,
  output logic        ILLEGAL
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH0, ST_FETCH1, ST_DECODE, ST_EXEC, ST_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir_q, pc_q;
  logic        step_q, illegal_q;
  logic        step_rise;

  // instruction decode, straight from the IR
  logic [3:0] opc, funct;
  logic is_alu, op_add, op_sub, op_and, op_or, op_xor, op_not;
  logic op_addi, op_ldin, op_halt, op_valid;

  assign opc     = ir_q[15:12];
  assign funct   = ir_q[7:4];
  assign is_alu  = (opc == 4'b0000);
  assign op_add  = is_alu && (funct == 4'b1010);
  assign op_sub  = is_alu && (funct == 4'b0010);
  assign op_and  = is_alu && (funct == 4'b1100);
  assign op_or   = is_alu && (funct == 4'b1110);
  assign op_xor  = is_alu && (funct == 4'b1101);
  assign op_not  = is_alu && (funct == 4'b1011);
  assign op_addi = (opc == 4'b0100);
  assign op_ldin = (opc == 4'b0010);
  assign op_halt = (opc == 4'b1111);
  assign op_valid = op_add | op_sub | op_and | op_or | op_xor | op_not | op_addi | op_ldin;

  // a STEP edge only matters in IDLE; elsewhere it simply goes unseen
  assign step_rise = STEP && !step_q;

  // state, IR, PC and status registers; reset wins in every state
  always_ff @(posedge CK) begin
    if (RST) begin
      state     <= ST_IDLE;
      ir_q      <= 16'h0000;
      pc_q      <= PC_RESET;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= STEP;
      if (state == ST_FETCH0 && MEM_ACK) ir_q[15:8] <= MEM_RDATA;
      if (state == ST_FETCH1 && MEM_ACK) begin
        ir_q[7:0] <= MEM_RDATA;
        pc_q      <= pc_q + 16'd2;
      end
      if (state == ST_DECODE && !op_valid && !op_halt) illegal_q <= 1'b1;
    end
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (RUN || step_rise) state_nxt = ST_FETCH0;
      ST_FETCH0: if (MEM_ACK) state_nxt = ST_FETCH1;
      ST_FETCH1: if (MEM_ACK) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = op_valid ? ST_EXEC : ST_HALT;
      ST_EXEC:   state_nxt = RUN ? ST_FETCH0 : ST_IDLE;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // memory handshake and EXEC-only datapath controls
  always_comb begin
    MEM_REQ  = 1'b0;
    MEM_ADDR = 16'h0000;
    REG_WE   = 1'b0;
    S_SUB    = 1'b0;
    S_FAS    = 1'b0;
    S_AND    = 1'b0;
    S_OR     = 1'b0;
    S_XOR    = 1'b0;
    S_NOT    = 1'b0;
    SEL_IMM  = 1'b0;
    SEL_LDIN = 1'b0;
    case (state)
      ST_FETCH0: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = pc_q;
      end
      ST_FETCH1: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = pc_q + 16'd1;
      end
      ST_EXEC: begin
        REG_WE   = 1'b1;
        S_FAS    = op_add | op_sub | op_addi;
        S_SUB    = op_sub;
        S_AND    = op_and;
        S_OR     = op_or;
        S_XOR    = op_xor;
        S_NOT    = op_not;
        SEL_IMM  = op_addi;
        SEL_LDIN = op_ldin;
      end
      default: ;
    endcase
  end

  assign IR      = ir_q;
  assign PC      = pc_q;
  assign REG_N1  = ir_q[11:8];
  assign REG_N2  = ir_q[3:0];
  assign REG_WN  = ir_q[11:8];
  assign IMM     = {{8{ir_q[7]}}, ir_q[7:0]};
  assign HALTED  = (state == ST_HALT);
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_my_cpu16_ctrl.sv
// Bench for my_cpu16_ctrl: table of single-stepped instructions scored at each
// REG_WE pulse, plus sequences for run timing, wait states, stepping, PC wrap
// and reset during a fetch.
module tb_my_cpu16_ctrl;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  // ---------------- DUT 1 (PC_RESET = 0) ----------------
  logic        rst, run, step;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, ir, pc, imm;
  logic [7:0]  mem_rdata;
  logic [3:0]  reg_n1, reg_n2, reg_wn;
  logic        reg_we, s_sub, s_fas, s_and, s_or, s_xor, s_not, sel_imm, sel_ldin;
  logic        halted, illegal;

  my_cpu16_ctrl #(.PC_RESET(16'h0000)) dut (
    .CK(CK), .RST(rst), .RUN(run), .STEP(step),
    .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata),
    .IR(ir), .PC(pc), .REG_N1(reg_n1), .REG_N2(reg_n2), .REG_WN(reg_wn), .REG_WE(reg_we),
    .S_SUB(s_sub), .S_FAS(s_fas), .S_AND(s_and), .S_OR(s_or), .S_XOR(s_xor), .S_NOT(s_not),
    .SEL_IMM(sel_imm), .IMM(imm), .SEL_LDIN(sel_ldin), .HALTED(halted), .ILLEGAL(illegal)
  );

  // byte memory with programmable wait states
  logic [7:0] mem [0:255];
  int ws = 0;
  int wcnt = 0;
  assign mem_ack   = mem_req && (wcnt == ws);
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge CK) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  // ---------------- DUT 2 (PC_RESET = FFFE) ----------------
  logic        rst2, run2, stall2, force2;
  logic        req2, ack2;
  logic [15:0] addr2, ir2, pc2, imm2;
  logic [7:0]  rdata2;
  logic [3:0]  n1_2, n2_2, wn2;
  logic        we2, sub2, fas2, and2, or2, xor2, not2, simm2, sldin2, halted2, ill2;

  my_cpu16_ctrl #(.PC_RESET(16'hFFFE)) dut2 (
    .CK(CK), .RST(rst2), .RUN(run2), .STEP(1'b0),
    .MEM_REQ(req2), .MEM_ADDR(addr2), .MEM_ACK(ack2), .MEM_RDATA(rdata2),
    .IR(ir2), .PC(pc2), .REG_N1(n1_2), .REG_N2(n2_2), .REG_WN(wn2), .REG_WE(we2),
    .S_SUB(sub2), .S_FAS(fas2), .S_AND(and2), .S_OR(or2), .S_XOR(xor2), .S_NOT(not2),
    .SEL_IMM(simm2), .IMM(imm2), .SEL_LDIN(sldin2), .HALTED(halted2), .ILLEGAL(ill2)
  );

  // FFFE: 00A1 (ADD), 0000: F000 (HALT)
  assign rdata2 = (addr2 == 16'hFFFF) ? 8'hA1 : (addr2 == 16'h0000) ? 8'hF0 : 8'h00;
  assign ack2   = (req2 && !(stall2 && addr2 == 16'hFFFF)) || force2;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // sel order: {S_SUB,S_FAS,S_AND,S_OR,S_XOR,S_NOT,SEL_IMM,SEL_LDIN}
  typedef struct {
    logic [7:0]  sel;
    logic [3:0]  wn;
    logic [3:0]  n2;
    logic [15:0] imm;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  sel;
    logic [3:0]  wn;
    logic [3:0]  n2;
    logic [15:0] imm;
    logic        hlt;
    logic        ill;
  } vec_t;

  exp_t        sbq[$];
  int          we_t[$];
  logic [15:0] we_ir[$];
  logic [15:0] addrq[$];
  int          cyc = 0;
  int          we2_cnt = 0;
  logic [15:0] we2_pc = 16'h1234;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  always @(posedge CK) cyc <= cyc + 1;

  // scoreboard: every REG_WE pulse must match the oldest pending expectation
  always @(negedge CK) begin
    exp_t e;
    if (reg_we) begin
      we_t.push_back(cyc);
      we_ir.push_back(ir);
      if (sbq.size() == 0) chk("unexpected_we", {16'h0, ir}, 32'hFFFF_FFFF);
      else begin
        e = sbq.pop_front();
        chk("exec_sel", {24'h0, s_sub, s_fas, s_and, s_or, s_xor, s_not, sel_imm, sel_ldin}, {24'h0, e.sel});
        chk("exec_wn",  {28'h0, reg_wn}, {28'h0, e.wn});
        chk("exec_n1",  {28'h0, reg_n1}, {28'h0, e.wn});
        chk("exec_n2",  {28'h0, reg_n2}, {28'h0, e.n2});
        chk("exec_imm", {16'h0, imm}, {16'h0, e.imm});
      end
    end else if ({s_sub, s_fas, s_and, s_or, s_xor, s_not, sel_imm, sel_ldin} != 8'h00)
      chk("sel_outside_exec", {24'h0, s_sub, s_fas, s_and, s_or, s_xor, s_not, sel_imm, sel_ldin}, 32'h0);
    if (mem_req && prev_req && !prev_ack) chk("addr_hold", {16'h0, mem_addr}, {16'h0, prev_addr});
    if (mem_req && mem_ack) addrq.push_back(mem_addr);
    prev_req  <= mem_req;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
    if (we2) begin
      we2_cnt <= we2_cnt + 1;
      we2_pc  <= pc2;
    end
  end

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge CK);
    rst = 1'b0;
    sbq.delete(); we_t.delete(); we_ir.delete(); addrq.delete();
  endtask

  task automatic load_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3);
    logic [15:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      mem[2*k]   = w[k][15:8];
      mem[2*k+1] = w[k][7:0];
    end
  endtask

  vec_t vt[12];
  int   t0;

  initial begin
    vt[0]  = '{16'h20CF, 8'h01, 4'h0, 4'hF, 16'hFFCF, 1'b0, 1'b0};
    vt[1]  = '{16'h00A1, 8'h40, 4'h0, 4'h1, 16'hFFA1, 1'b0, 1'b0};
    vt[2]  = '{16'h0321, 8'hC0, 4'h3, 4'h1, 16'h0021, 1'b0, 1'b0};
    vt[3]  = '{16'h05C2, 8'h20, 4'h5, 4'h2, 16'hFFC2, 1'b0, 1'b0};
    vt[4]  = '{16'h07E2, 8'h10, 4'h7, 4'h2, 16'hFFE2, 1'b0, 1'b0};
    vt[5]  = '{16'h09D2, 8'h08, 4'h9, 4'h2, 16'hFFD2, 1'b0, 1'b0};
    vt[6]  = '{16'h0AB2, 8'h04, 4'hA, 4'h2, 16'hFFB2, 1'b0, 1'b0};
    vt[7]  = '{16'h4123, 8'h42, 4'h1, 4'h3, 16'h0023, 1'b0, 1'b0};
    vt[8]  = '{16'h41FF, 8'h42, 4'h1, 4'hF, 16'hFFFF, 1'b0, 1'b0};
    vt[9]  = '{16'h7000, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b1};
    vt[10] = '{16'h0F52, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b1};
    vt[11] = '{16'hF000, 8'h00, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0};

    rst2 = 1'b1; run2 = 1'b0; stall2 = 1'b0; force2 = 1'b0;
    load_words(16'h0, 16'h0, 16'h0, 16'h0);

    // reset state
    rst = 1'b1; run = 1'b1; step = 1'b1;
    repeat (2) @(negedge CK);
    chk("rst_req",  {31'h0, mem_req}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_ir",   {16'h0, ir}, 32'h0);
    chk("rst_pc",   {16'h0, pc}, 32'h0);
    chk("rst_ctl",  {25'h0, reg_we, halted, illegal, reg_n1}, 32'h0);
    chk("rst_imm",  {16'h0, imm}, 32'h0);

    // table: one single-stepped instruction per vector
    for (int i = 0; i < 12; i++) begin
      load_words(vt[i].word, 16'hF000, 16'h0, 16'h0);
      do_reset();
      if (!vt[i].hlt) sbq.push_back('{vt[i].sel, vt[i].wn, vt[i].n2, vt[i].imm});
      step = 1'b1; @(negedge CK); step = 1'b0;
      repeat (8) @(negedge CK);
      chk("tbl_halted",  {31'h0, halted}, {31'h0, vt[i].hlt});
      chk("tbl_illegal", {31'h0, illegal}, {31'h0, vt[i].ill});
      chk("tbl_pc",      {16'h0, pc}, 32'h2);
      chk("tbl_req",     {31'h0, mem_req}, 32'h0);
      chk("tbl_pending", sbq.size(), 32'h0);
      if (vt[i].hlt) begin
        run = 1'b1; step = 1'b1; @(negedge CK); step = 1'b0;
        repeat (8) @(negedge CK);
        chk("halt_sticky", {30'h0, halted, illegal}, {30'h0, 1'b1, vt[i].ill});
        chk("halt_pc",     {16'h0, pc}, 32'h2);
        run = 1'b0;
      end
    end

    // run with zero-wait memory: 20CF 21CF 00A1
    load_words(16'h20CF, 16'h21CF, 16'h00A1, 16'hF000);
    do_reset();
    sbq.push_back('{8'h01, 4'h0, 4'hF, 16'hFFCF});
    sbq.push_back('{8'h01, 4'h1, 4'hF, 16'hFFCF});
    sbq.push_back('{8'h40, 4'h0, 4'h1, 16'hFFA1});
    run = 1'b1; t0 = cyc;
    repeat (24) @(negedge CK);
    chk("run_we_count", we_t.size(), 32'd4 - 32'd1);
    for (int k = 0; k < 6; k++)
      chk("run_addr_seq", (addrq.size() > k) ? {16'h0, addrq[k]} : 32'hDEAD, k);
    for (int k = 0; k < 3; k++)
      chk("run_we_cycle", (we_t.size() > k) ? we_t[k] - t0 : -1, 4 * (k + 1));
    chk("run_halt", {30'h0, halted, illegal}, 32'h2);

    // three wait states per byte; RUN drops during the second instruction
    ws = 3;
    load_words(16'h20CF, 16'h21CF, 16'hF000, 16'h0);
    do_reset();
    sbq.push_back('{8'h01, 4'h0, 4'hF, 16'hFFCF});
    sbq.push_back('{8'h01, 4'h1, 4'hF, 16'hFFCF});
    run = 1'b1; t0 = cyc;
    for (int k = 0; k < 40 && we_t.size() < 1; k++) @(negedge CK);
    chk("ws_first_we_seen", we_t.size(), 32'd1);
    repeat (2) @(negedge CK);
    run = 1'b0;
    repeat (30) @(negedge CK);
    chk("ws_we_count", we_t.size(), 32'd2);
    chk("ws_first_lat", (we_t.size() > 0) ? we_t[0] - t0 : -1, 32'd10);
    chk("ws_interval", (we_t.size() > 1) ? we_t[1] - we_t[0] : -1, 32'd10);
    chk("ws_ir", (we_ir.size() > 0) ? {16'h0, we_ir[0]} : 32'hDEAD, 32'h20CF);
    chk("ws_idle", {15'h0, mem_req, halted, pc}, 32'h0004);
    ws = 0;

    // single stepping; an edge mid-instruction is dropped, a held level does nothing
    load_words(16'h20CF, 16'h21CF, 16'h00A1, 16'h0);
    do_reset();
    sbq.push_back('{8'h01, 4'h0, 4'hF, 16'hFFCF});
    sbq.push_back('{8'h01, 4'h1, 4'hF, 16'hFFCF});
    step = 1'b1; @(negedge CK);
    step = 1'b0; @(negedge CK);
    step = 1'b1; @(negedge CK);
    step = 1'b0;
    repeat (6) @(negedge CK);
    chk("step_one", we_t.size(), 32'd1);
    step = 1'b1;
    repeat (20) @(negedge CK);
    step = 1'b0;
    chk("step_two", we_t.size(), 32'd2);
    chk("step_pc", {16'h0, pc}, 32'h4);
    chk("step_idle", {30'h0, mem_req, halted}, 32'h0);

    // PC wrap from FFFE
    @(negedge CK); rst2 = 1'b0; run2 = 1'b1;
    repeat (14) @(negedge CK);
    chk("wrap_we_count", we2_cnt, 32'd1);
    chk("wrap_pc_at_we", {16'h0, we2_pc}, 32'h0);
    chk("wrap_halt", {30'h0, halted2, ill2}, 32'h2);
    chk("wrap_pc_end", {16'h0, pc2}, 32'h2);

    // reset in FETCH1, then a stray ACK
    stall2 = 1'b1; rst2 = 1'b1; run2 = 1'b0;
    repeat (2) @(negedge CK);
    rst2 = 1'b0; run2 = 1'b1;
    for (int k = 0; k < 20 && !(req2 && addr2 == 16'hFFFF); k++) @(negedge CK);
    chk("f1_reached", {15'h0, req2, addr2}, 32'h1FFFF);
    rst2 = 1'b1; run2 = 1'b0;
    @(negedge CK);
    chk("f1_rst_req", {31'h0, req2}, 32'h0);
    chk("f1_rst_pc",  {16'h0, pc2}, 32'hFFFE);
    chk("f1_rst_ir",  {16'h0, ir2}, 32'h0);
    rst2 = 1'b0; stall2 = 1'b0; force2 = 1'b1;
    @(negedge CK);
    force2 = 1'b0;
    repeat (2) @(negedge CK);
    chk("late_ack_ir",   {16'h0, ir2}, 32'h0);
    chk("late_ack_idle", {14'h0, req2, halted2, pc2}, 32'hFFFE);
    chk("late_ack_we",   we2_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
